mipi_rx_pkt_parser: RTL

- Parses the merged 32-bit CSI-2 lane word stream into packet headers and payload.
- Drives the command interface (data type, valid) consumed by the frame-sync/vsync stage, plus a payload word stream for the pixel unpacker.
- Checks the header ECC, tracks long-packet word count and strips CRC bytes.
- Sits between the lane-merge stage and the vsync/unpack stages.

---
 rtl/mipi_rx_pkt_parser.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mipi_rx_pkt_parser.sv
// rtl/mipi_rx_pkt_parser.sv - CSI-2 receive packet parser: header decode, ECC check, payload/CRC split
//
// Purpose:
//   Takes the merged 32-bit lane word stream and splits it into packet headers
//   (command interface for the frame-sync stage) and payload words (for the
//   pixel unpacker). Long-packet CRC bytes are consumed but not forwarded.
//
// Ports:
//   CLKn              in   byte-clock-domain clock
//   RSTn              in   asynchronous active-low reset
//   Rx_word[31:0]     in   merged lane word, byte0 = [7:0] first on the wire
//   Rx_word_valid     in   word qualifier, low = stall
//   Rx_sot            in   header-word marker (qualified by Rx_word_valid)
//   Rx_cmd_data_type  out  DT of last accepted header
//   Rx_cmd_vc         out  VC of last accepted header
//   Rx_cmd_word_count out  WC field of last accepted header
//   Rx_cmd_valid      out  one-cycle pulse per accepted header
//   Rx_data[31:0]     out  payload word (holds last strobed word)
//   Rx_data_be[3:0]   out  byte enables for Rx_data
//   Rx_data_valid     out  payload word strobe
//   Rx_data_last      out  last payload word of the packet
//   Rx_ecc_err        out  one-cycle pulse on header ECC mismatch
//   Rx_pkt_abort      out  one-cycle pulse when sot truncates a long packet

module mipi_rx_pkt_parser #(
  parameter bit         ECC_EN      = 1'b1,
  parameter logic [5:0] LONG_DT_MIN = 6'h10
) (
  input  logic        CLKn,
  input  logic        RSTn,
  input  logic [31:0] Rx_word,
  input  logic        Rx_word_valid,
  input  logic        Rx_sot,
  output logic [5:0]  Rx_cmd_data_type,
  output logic [1:0]  Rx_cmd_vc,
  output logic [15:0] Rx_cmd_word_count,
  output logic        Rx_cmd_valid,
  output logic [31:0] Rx_data,
  output logic [3:0]  Rx_data_be,
  output logic        Rx_data_valid,
  output logic        Rx_data_last,
  output logic        Rx_ecc_err,
  output logic        Rx_pkt_abort
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_data_rem, w_data_rem_nxt;
  // WC + 2 CRC bytes needs 17 bits so WC = 16'hFFFF cannot wrap.
  logic [16:0] r_tot_rem, w_tot_rem_nxt;

  logic [5:0]  r_cmd_dt;
  logic [1:0]  r_cmd_vc;
  logic [15:0] r_cmd_wc;
  logic        r_cmd_valid, w_cmd_valid_nxt;
  logic [31:0] r_data;
  logic [3:0]  r_data_be, w_data_be_nxt;
  logic        r_data_valid, w_data_valid_nxt;
  logic        r_data_last, w_data_last_nxt;
  logic        r_ecc_err, w_ecc_err_nxt;
  logic        r_pkt_abort, w_pkt_abort_nxt;
  logic        w_hdr_load;

  logic [5:0]  w_ecc_calc;
  logic        w_ecc_bad;

  // CSI-2 header Hamming code over the 24 header data bits.
  function automatic logic [5:0] f_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  assign w_ecc_calc = f_ecc(Rx_word[23:0]);
  // Comparing the full byte also rejects headers with P7:P6 set.
  assign w_ecc_bad  = (Rx_word[31:24] != {2'b00, w_ecc_calc});

  always_comb begin
    w_state_nxt      = r_state;
    w_data_rem_nxt   = r_data_rem;
    w_tot_rem_nxt    = r_tot_rem;
    w_cmd_valid_nxt  = 1'b0;
    w_data_be_nxt    = 4'b0000;
    w_data_valid_nxt = 1'b0;
    w_data_last_nxt  = 1'b0;
    w_ecc_err_nxt    = 1'b0;
    w_pkt_abort_nxt  = 1'b0;
    w_hdr_load       = 1'b0;

    if (Rx_word_valid) begin
      if (Rx_sot) begin
        // A header always wins, whatever state we are in; truncating a
        // long packet is flagged but its last-word marker is never sent.
        w_pkt_abort_nxt = (r_state == PAYLOAD);
        if (ECC_EN && w_ecc_bad) begin
          w_ecc_err_nxt = 1'b1;
          w_state_nxt   = DROP;
        end else begin
          w_cmd_valid_nxt = 1'b1;
          w_hdr_load      = 1'b1;
          if (Rx_word[5:0] >= LONG_DT_MIN) begin
            w_data_rem_nxt = Rx_word[23:8];
            w_tot_rem_nxt  = {1'b0, Rx_word[23:8]} + 17'd2;
            w_state_nxt    = PAYLOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end else if (r_state == PAYLOAD) begin
        if (r_data_rem >= 16'd4) begin
          w_data_be_nxt = 4'b1111;
        end else begin
          case (r_data_rem[1:0])
            2'd3:    w_data_be_nxt = 4'b0111;
            2'd2:    w_data_be_nxt = 4'b0011;
            2'd1:    w_data_be_nxt = 4'b0001;
            default: w_data_be_nxt = 4'b0000;
          endcase
        end
        w_data_valid_nxt = (w_data_be_nxt != 4'b0000);
        w_data_last_nxt  = (r_data_rem != 16'd0) && (r_data_rem <= 16'd4);
        w_data_rem_nxt   = (r_data_rem >= 16'd4) ? (r_data_rem - 16'd4) : 16'd0;
        w_tot_rem_nxt    = (r_tot_rem > 17'd4) ? (r_tot_rem - 17'd4) : 17'd0;
        if (r_tot_rem <= 17'd4) begin
          w_state_nxt = IDLE;
        end
      end
    end
  end

  always_ff @(posedge CLKn or negedge RSTn) begin
    if (!RSTn) begin
      r_state      <= IDLE;
      r_data_rem   <= 16'd0;
      r_tot_rem    <= 17'd0;
      r_cmd_dt     <= 6'd0;
      r_cmd_vc     <= 2'd0;
      r_cmd_wc     <= 16'd0;
      r_cmd_valid  <= 1'b0;
      r_data       <= 32'd0;
      r_data_be    <= 4'b0000;
      r_data_valid <= 1'b0;
      r_data_last  <= 1'b0;
      r_ecc_err    <= 1'b0;
      r_pkt_abort  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_data_rem   <= w_data_rem_nxt;
      r_tot_rem    <= w_tot_rem_nxt;
      r_cmd_valid  <= w_cmd_valid_nxt;
      r_data_be    <= w_data_be_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_data_last  <= w_data_last_nxt;
      r_ecc_err    <= w_ecc_err_nxt;
      r_pkt_abort  <= w_pkt_abort_nxt;
      if (w_hdr_load) begin
        r_cmd_dt <= Rx_word[5:0];
        r_cmd_vc <= Rx_word[7:6];
        r_cmd_wc <= Rx_word[23:8];
      end
      if (w_data_valid_nxt) begin
        r_data <= Rx_word;
      end
    end
  end

  assign Rx_cmd_data_type  = r_cmd_dt;
  assign Rx_cmd_vc         = r_cmd_vc;
  assign Rx_cmd_word_count = r_cmd_wc;
  assign Rx_cmd_valid      = r_cmd_valid;
  assign Rx_data           = r_data;
  assign Rx_data_be        = r_data_be;
  assign Rx_data_valid     = r_data_valid;
  assign Rx_data_last      = r_data_last;
  assign Rx_ecc_err        = r_ecc_err;
  assign Rx_pkt_abort      = r_pkt_abort;

endmodule
